// File: rtl/icache_refill_if.sv
// icache_refill_if: miss, memory and refill signals between the refill unit and its neighbours
interface icache_refill_if #(
  parameter int PLEN    = 32,
  parameter int LINE_W  = 256,
  parameter int MEM_W   = 64,
  parameter int INDEX_W = 7,
  parameter int TAG_W   = 20,
  parameter int WAY_W   = 2
);
  logic               miss_valid_i;
  logic               miss_ready_o;
  logic [PLEN-1:0]    miss_paddr_i;
  logic               mem_req_valid_o;
  logic               mem_req_ready_i;
  logic [PLEN-1:0]    mem_req_addr_o;
  logic               mem_rsp_valid_i;
  logic [MEM_W-1:0]   mem_rsp_data_i;
  logic               refill_valid_o;
  logic [WAY_W-1:0]   refill_way_o;
  logic [INDEX_W-1:0] refill_index_o;
  logic [TAG_W-1:0]   refill_tag_o;
  logic [LINE_W-1:0]  refill_data_o;
  modport master (
    input  miss_valid_i, miss_paddr_i, mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i,
    output miss_ready_o, mem_req_valid_o, mem_req_addr_o,
           refill_valid_o, refill_way_o, refill_index_o, refill_tag_o, refill_data_o
  );
  modport slave (
    output miss_valid_i, miss_paddr_i, mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i,
    input  miss_ready_o, mem_req_valid_o, mem_req_addr_o,
           refill_valid_o, refill_way_o, refill_index_o, refill_tag_o, refill_data_o
  );
endinterface

// File: rtl/icache_refill_unit.sv
// icache_refill_unit: fetches one missed line as memory beats and writes it into the ICache arrays
module icache_refill_unit #(
  parameter int PLEN                = 32,
  parameter int ICACHE_LINE_WIDTH   = 256,
  parameter int ICACHE_SET_ASSOC    = 4,
  parameter int ICACHE_INDEX_WIDTH  = 7,
  parameter int ICACHE_OFFSET_WIDTH = 5,
  parameter int ICACHE_TAG_WIDTH    = 20,
  parameter int MEM_DATA_WIDTH      = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  output logic busy_o,
  icache_refill_if.master bus
);
  localparam int BEATS = ICACHE_LINE_WIDTH / MEM_DATA_WIDTH;
  localparam int BW    = $clog2(BEATS);
  localparam int WAY_W = ICACHE_SET_ASSOC > 1 ? $clog2(ICACHE_SET_ASSOC) : 1;
  localparam int AW    = PLEN - ICACHE_OFFSET_WIDTH;
  typedef enum logic [1:0] {IDLE, REQ, RECV, WRITE} state_e;
  state_e                        state_q, state_d;
  logic [BW-1:0]                 cnt_q, cnt_d;
  logic [WAY_W-1:0]              vptr_q, vptr_d, rway_q, rway_d;
  logic                          kill_q, kill_d, wr_en;
  logic [ICACHE_LINE_WIDTH-1:0]  line_q, line_d, rdata_q, rdata_d;
  logic [AW-1:0]                 addr_q, addr_d;
  logic [ICACHE_INDEX_WIDTH-1:0] ridx_q, ridx_d;
  logic [ICACHE_TAG_WIDTH-1:0]   rtag_q, rtag_d;
  assign wr_en               = state_q == WRITE && !kill_q && !flush_i;
  assign busy_o              = state_q != IDLE;
  assign bus.mem_req_addr_o  = {addr_q, ICACHE_OFFSET_WIDTH'(0)};
  assign bus.refill_valid_o  = wr_en;
  assign bus.refill_way_o    = rway_q;
  assign bus.refill_index_o  = ridx_q;
  assign bus.refill_tag_o    = rtag_q;
  assign bus.refill_data_o   = rdata_q;
  // Refill outputs are captured on the last beat so they stay stable while the next line assembles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vptr_d  = vptr_q;
    kill_d  = kill_q;
    line_d  = line_q;
    addr_d  = addr_q;
    rway_d  = rway_q;
    ridx_d  = ridx_q;
    rtag_d  = rtag_q;
    rdata_d = rdata_q;
    bus.miss_ready_o    = 1'b0;
    bus.mem_req_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        bus.miss_ready_o = !flush_i;
        if (bus.miss_valid_i && !flush_i) begin
          addr_d  = bus.miss_paddr_i[PLEN-1:ICACHE_OFFSET_WIDTH];
          state_d = REQ;
        end
      end
      REQ: begin
        bus.mem_req_valid_o = 1'b1;
        kill_d = kill_q | flush_i;
        if (bus.mem_req_ready_i) begin
          cnt_d   = '0;
          state_d = RECV;
        end
      end
      RECV: begin
        kill_d = kill_q | flush_i;
        if (bus.mem_rsp_valid_i) begin
          line_d[32'(cnt_q)*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] = bus.mem_rsp_data_i;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == BW'(BEATS-1)) begin
            rdata_d = line_d;
            ridx_d  = addr_q[ICACHE_INDEX_WIDTH-1:0];
            rtag_d  = addr_q[AW-1 -: ICACHE_TAG_WIDTH];
            rway_d  = vptr_q;
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        vptr_d  = !wr_en ? vptr_q : vptr_q == WAY_W'(ICACHE_SET_ASSOC-1) ? '0 : vptr_q + 1'b1;
        kill_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      vptr_q  <= '0;
      kill_q  <= 1'b0;
      line_q  <= '0;
      addr_q  <= '0;
      rway_q  <= '0;
      ridx_q  <= '0;
      rtag_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vptr_q  <= vptr_d;
      kill_q  <= kill_d;
      line_q  <= line_d;
      addr_q  <= addr_d;
      rway_q  <= rway_d;
      ridx_q  <= ridx_d;
      rtag_q  <= rtag_d;
      rdata_q <= rdata_d;
    end
  end
endmodule

// File: tb/tb_icache_refill_unit.sv
// tb_icache_refill_unit: directed misses with a refill/request scoreboard checked by a separate monitor
module tb_icache_refill_unit;
  logic clk = 0, rst_n = 0, flush = 0, busy;
  int total = 0, bad = 0;
  typedef struct packed {
    logic [1:0]   way;
    logic [6:0]   idx;
    logic [19:0]  tag;
    logic [255:0] data;
  } exp_t;
  exp_t        exp_q[$];
  logic [31:0] req_q[$];
  logic [1:0]  way_m = 0;
  icache_refill_if bus ();
  icache_refill_unit dut (.clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .busy_o(busy), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [255:0] mk(input logic [15:0] s);
    return {{4{s + 16'd3}}, {4{s + 16'd2}}, {4{s + 16'd1}}, {4{s}}};
  endfunction
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.refill_valid_o) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_refill idx=%0h", bus.refill_index_o);
        end else begin
          e = exp_q.pop_front();
          check("refill_way", bus.refill_way_o, e.way);
          check("refill_index", bus.refill_index_o, e.idx);
          check("refill_tag", bus.refill_tag_o, e.tag);
          check("refill_data", bus.refill_data_o, e.data);
        end
      end
      if (bus.mem_req_valid_o && bus.mem_req_ready_i) begin
        if (req_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_req addr=%0h", bus.mem_req_addr_o);
        end else check("req_addr", bus.mem_req_addr_o, req_q.pop_front());
      end
    end
  end
  // fb: beat index (0..3) to flush on, 4 = flush in the write cycle, -1 = no flush.
  task automatic run_miss(input logic [31:0] pa, input logic [255:0] line, input int rw,
                          input int gap, input int fb, input bit hold, input logic [31:0] npa);
    bit wr = fb < 0;
    req_q.push_back({pa[31:5], 5'b0});
    if (wr) begin
      exp_q.push_back(exp_t'{way_m, pa[11:5], pa[31:12], line});
      way_m++;
    end
    bus.miss_valid_i = 1;
    bus.miss_paddr_i = pa;
    #1 check("miss_ready_idle", bus.miss_ready_o, 1);
    tick;
    bus.miss_valid_i = hold;
    bus.miss_paddr_i = npa;
    #1 check("req_valid", bus.mem_req_valid_o, 1);
    check("req_addr_early", bus.mem_req_addr_o, {pa[31:5], 5'b0});
    for (int i = 0; i < rw; i++) begin
      tick;
      check("req_valid_held", bus.mem_req_valid_o, 1);
      check("req_addr_held", bus.mem_req_addr_o, {pa[31:5], 5'b0});
      check("miss_ready_busy", bus.miss_ready_o, 0);
    end
    bus.mem_req_ready_i = 1;
    tick;
    bus.mem_req_ready_i = 0;
    for (int b = 0; b < 4; b++) begin
      repeat (gap) tick;
      bus.mem_rsp_valid_i = 1;
      bus.mem_rsp_data_i  = line[b*64 +: 64];
      flush = fb == b;
      check("busy_recv", busy, 1);
      tick;
      bus.mem_rsp_valid_i = 0;
      flush = 0;
    end
    flush = fb == 4;
    #1 check("refill_strobe", bus.refill_valid_o, wr);
    check("miss_ready_write", bus.miss_ready_o, 0);
    tick;
    flush = 0;
    #1 check("idle_after_write", busy, 0);
  endtask
  initial begin
    bus.miss_valid_i    = 0;
    bus.miss_paddr_i    = 0;
    bus.mem_req_ready_i = 0;
    bus.mem_rsp_valid_i = 0;
    bus.mem_rsp_data_i  = 0;
    #1;
    check("rst_miss_ready", bus.miss_ready_o, 1);
    check("rst_busy", busy, 0);
    check("rst_req_valid", bus.mem_req_valid_o, 0);
    check("rst_req_addr", bus.mem_req_addr_o, 0);
    check("rst_refill_valid", bus.refill_valid_o, 0);
    check("rst_refill_data", bus.refill_data_o, 0);
    repeat (2) tick;
    rst_n = 1;
    run_miss(32'h8000_1234, {64'h3, 64'h2, 64'h1, 64'h0}, 0, 0, -1, 0, 0);
    check("first_index", bus.refill_index_o, 7'h11);
    check("first_tag", bus.refill_tag_o, 20'h80001);
    run_miss(32'h0000_0040, mk(16'h1000), 0, 0, -1, 0, 0);
    run_miss(32'h1234_5660, mk(16'h2000), 0, 0, -1, 0, 0);
    run_miss(32'hFFFF_FFE0, mk(16'h3000), 0, 0, -1, 0, 0);
    run_miss(32'h0000_1000, mk(16'h4000), 0, 0, -1, 0, 0);
    run_miss(32'h2000_0100, mk(16'h5000), 5, 0, -1, 1, 32'h2000_0200);
    run_miss(32'h2000_0200, mk(16'h6000), 0, 0, -1, 0, 0);
    run_miss(32'h3000_0000, mk(16'h7000), 0, 0, 1, 0, 0);
    run_miss(32'h3000_0020, mk(16'h8000), 0, 0, -1, 0, 0);
    bus.miss_valid_i = 1;
    bus.miss_paddr_i = 32'h4000_0040;
    flush = 1;
    #1 check("miss_ready_flush", bus.miss_ready_o, 0);
    tick;
    flush = 0;
    bus.miss_valid_i = 0;
    #1 check("flush_not_accepted", busy, 0);
    run_miss(32'h4000_0040, mk(16'h9000), 0, 0, -1, 0, 0);
    run_miss(32'h4000_0080, mk(16'hA000), 0, 0, 4, 0, 0);
    bus.mem_rsp_valid_i = 1;
    bus.mem_rsp_data_i  = 64'hDEAD_BEEF_DEAD_BEEF;
    tick;
    bus.mem_rsp_valid_i = 0;
    #1 check("stray_beat_idle", busy, 0);
    run_miss(32'h5000_0FE0, mk(16'hB000), 1, 2, -1, 0, 0);
    req_q.push_back(32'h6000_0040);
    bus.miss_valid_i = 1;
    bus.miss_paddr_i = 32'h6000_0044;
    tick;
    bus.miss_valid_i = 0;
    bus.mem_req_ready_i = 1;
    tick;
    bus.mem_req_ready_i = 0;
    bus.mem_rsp_valid_i = 1;
    bus.mem_rsp_data_i  = 64'h1234;
    tick;
    bus.mem_rsp_valid_i = 0;
    #2 rst_n = 0;
    #1 check("rst_mid_busy", busy, 0);
    check("rst_mid_miss_ready", bus.miss_ready_o, 1);
    check("rst_mid_req_valid", bus.mem_req_valid_o, 0);
    check("rst_mid_refill_valid", bus.refill_valid_o, 0);
    check("rst_mid_refill_data", bus.refill_data_o, 0);
    check("rst_mid_refill_way", bus.refill_way_o, 0);
    way_m = 0;
    tick;
    rst_n = 1;
    run_miss(32'h6000_0000, mk(16'hC000), 0, 0, -1, 0, 0);
    repeat (3) tick;
    check("refills_outstanding", exp_q.size(), 0);
    check("reqs_outstanding", req_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
